// File: rtl/ft245_target.sv
// rtl/ft245_target.sv - FT245-style asynchronous FIFO device end with AXI-Stream byte ports
module ft245_target #(
    parameter int FIFO_DEPTH      = 16,
    parameter int RXF_HOLD_CYCLES = 2,
    parameter int TXE_HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ft245_d_in,
    output logic [7:0] ft245_d_out,
    output logic       ft245_d_oe,
    input  logic       ft245_rd_n,
    input  logic       ft245_wr_n,
    output logic       ft245_rxf_n,
    output logic       ft245_txe_n,
    input  logic [7:0] input_axis_tdata,
    input  logic       input_axis_tvalid,
    output logic       input_axis_tready,
    output logic [7:0] output_axis_tdata,
    output logic       output_axis_tvalid,
    input  logic       output_axis_tready,
    output logic       protocol_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = 8;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_HOLD} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_HOLD} wstate_t;

    // Strobe/data synchronizers plus edge-history flops
    logic       rd_sync1_q, rd_sync2_q, rd_hist_q;
    logic       wr_sync1_q, wr_sync2_q, wr_hist_q;
    logic [7:0] din_sync1_q, din_sync2_q;

    // RX FIFO (toward host)
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic          rx_tready_q;
    logic          rx_push, rx_pop, rx_empty;

    // TX FIFO (from host)
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q;
    logic [CW-1:0] tx_count_q, tx_count_d;
    logic          tx_push, tx_pop, tx_full;

    // FSM state
    rstate_t       rstate_q, rstate_d;
    wstate_t       wstate_q, wstate_d;
    logic [HW-1:0] rhold_q, rhold_d;
    logic [HW-1:0] whold_q, whold_d;
    logic [7:0]    d_out_q, d_out_d;
    logic          d_oe_q, d_oe_d;
    logic          rd_got_q, rd_got_d;
    logic          rxf_n_q, txe_n_q;
    logic          err_q;
    logic          rd_err, wr_err, both_err;

    logic rd_fall, rd_rise, wr_fall, wr_rise;

    assign rd_fall  = rd_hist_q & ~rd_sync2_q;
    assign rd_rise  = ~rd_hist_q & rd_sync2_q;
    assign wr_fall  = wr_hist_q & ~wr_sync2_q;
    assign wr_rise  = ~wr_hist_q & wr_sync2_q;
    // Flag only the first cycle of an overlap so a long overlap gives one pulse
    assign both_err = (~rd_sync2_q & ~wr_sync2_q) & ~(~rd_hist_q & ~wr_hist_q);

    assign rx_empty = (rx_count_q == '0);
    assign tx_full  = (tx_count_q == DEPTH_C);
    assign rx_push  = input_axis_tvalid & rx_tready_q;
    assign tx_pop   = output_axis_tvalid & output_axis_tready;
    assign rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    assign tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_pop);

    assign ft245_d_out        = d_out_q;
    assign ft245_d_oe         = d_oe_q;
    assign ft245_rxf_n        = rxf_n_q;
    assign ft245_txe_n        = txe_n_q;
    assign input_axis_tready  = rx_tready_q;
    assign output_axis_tvalid = (tx_count_q != '0);
    assign output_axis_tdata  = tx_mem[tx_rptr_q];
    assign protocol_err       = err_q;

    // Two-flop synchronizers; data follows the write strobe depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync1_q  <= 1'b1;
            rd_sync2_q  <= 1'b1;
            rd_hist_q   <= 1'b1;
            wr_sync1_q  <= 1'b1;
            wr_sync2_q  <= 1'b1;
            wr_hist_q   <= 1'b1;
            din_sync1_q <= 8'h00;
            din_sync2_q <= 8'h00;
        end else begin
            rd_sync1_q  <= ft245_rd_n;
            rd_sync2_q  <= rd_sync1_q;
            rd_hist_q   <= rd_sync2_q;
            wr_sync1_q  <= ft245_wr_n;
            wr_sync2_q  <= wr_sync1_q;
            wr_hist_q   <= wr_sync2_q;
            din_sync1_q <= ft245_d_in;
            din_sync2_q <= din_sync1_q;
        end
    end

    // FIFO storage; contents need no reset since counts gate every read
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= input_axis_tdata;
        if (tx_push) tx_mem[tx_wptr_q] <= din_sync2_q;
    end

    // Read FSM next-state: present head on rd fall, pop on rd rise, then hold off
    always_comb begin
        rstate_d = rstate_q;
        rhold_d  = rhold_q;
        d_out_d  = d_out_q;
        d_oe_d   = d_oe_q;
        rd_got_d = rd_got_q;
        rx_pop   = 1'b0;
        rd_err   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (rd_fall) begin
                    d_out_d  = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
                    d_oe_d   = 1'b1;
                    rd_got_d = ~rx_empty;
                    rd_err   = rx_empty;
                    rstate_d = R_ACTIVE;
                end
            end
            R_ACTIVE: begin
                if (rd_rise) begin
                    // Pop only the byte actually shown to the host
                    rx_pop   = rd_got_q;
                    rd_got_d = 1'b0;
                    d_oe_d   = 1'b0;
                    rhold_d  = HW'(RXF_HOLD_CYCLES);
                    rstate_d = R_HOLD;
                end
            end
            R_HOLD: begin
                if (rd_fall | rd_rise) rd_err = 1'b1;
                if (rhold_q <= HW'(1)) begin
                    rhold_d  = '0;
                    rstate_d = R_IDLE;
                end else begin
                    rhold_d = rhold_q - HW'(1);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Write FSM next-state: capture on wr fall, hold off after wr rise
    always_comb begin
        wstate_d = wstate_q;
        whold_d  = whold_q;
        tx_push  = 1'b0;
        wr_err   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (wr_fall) begin
                    tx_push  = ~tx_full;
                    wr_err   = tx_full;
                    wstate_d = W_ACTIVE;
                end
            end
            W_ACTIVE: begin
                if (wr_rise) begin
                    whold_d  = HW'(TXE_HOLD_CYCLES);
                    wstate_d = W_HOLD;
                end
            end
            W_HOLD: begin
                if (wr_fall | wr_rise) wr_err = 1'b1;
                if (whold_q <= HW'(1)) begin
                    whold_d  = '0;
                    wstate_d = W_IDLE;
                end else begin
                    whold_d = whold_q - HW'(1);
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // State, pointers, counts and registered flow-control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q    <= R_IDLE;
            wstate_q    <= W_IDLE;
            rhold_q     <= '0;
            whold_q     <= '0;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            rd_got_q    <= 1'b0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_count_q  <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_count_q  <= '0;
            rx_tready_q <= 1'b0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            rstate_q    <= rstate_d;
            wstate_q    <= wstate_d;
            rhold_q     <= rhold_d;
            whold_q     <= whold_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            rd_got_q    <= rd_got_d;
            if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
            if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
            rx_count_q  <= rx_count_d;
            tx_count_q  <= tx_count_d;
            rx_tready_q <= (rx_count_d < DEPTH_C);
            rxf_n_q     <= !((rx_count_d != '0) && (rstate_d == R_IDLE) && (rhold_d == '0));
            txe_n_q     <= !((tx_count_d < DEPTH_C) && (wstate_d == W_IDLE) && (whold_d == '0));
            err_q       <= rd_err | wr_err | both_err;
        end
    end

endmodule

// File: tb/tb_ft245_target.sv
// tb/tb_ft245_target.sv - directed self-checking bench for ft245_target
module tb_ft245_target;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ft245_d_in;
    logic [7:0] ft245_d_out;
    logic       ft245_d_oe;
    logic       ft245_rd_n;
    logic       ft245_wr_n;
    logic       ft245_rxf_n;
    logic       ft245_txe_n;
    logic [7:0] input_axis_tdata;
    logic       input_axis_tvalid;
    logic       input_axis_tready;
    logic [7:0] output_axis_tdata;
    logic       output_axis_tvalid;
    logic       output_axis_tready;
    logic       protocol_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    ft245_target #(
        .FIFO_DEPTH(16),
        .RXF_HOLD_CYCLES(2),
        .TXE_HOLD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ft245_d_in(ft245_d_in),
        .ft245_d_out(ft245_d_out),
        .ft245_d_oe(ft245_d_oe),
        .ft245_rd_n(ft245_rd_n),
        .ft245_wr_n(ft245_wr_n),
        .ft245_rxf_n(ft245_rxf_n),
        .ft245_txe_n(ft245_txe_n),
        .input_axis_tdata(input_axis_tdata),
        .input_axis_tvalid(input_axis_tvalid),
        .input_axis_tready(input_axis_tready),
        .output_axis_tdata(output_axis_tdata),
        .output_axis_tvalid(output_axis_tvalid),
        .output_axis_tready(output_axis_tready),
        .protocol_err(protocol_err)
    );

    always @(negedge clk) begin
        if (rst_n && protocol_err) err_pulses++;
    end

    typedef struct {
        bit         is_wr;
        bit         feed_en;
        logic [7:0] data;
        logic [7:0] exp;
        int         exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input logic [7:0] b);
        bit hs;
        hs = 1'b0;
        input_axis_tdata  = b;
        input_axis_tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            hs = input_axis_tready;
            tick(1);
            if (hs) break;
        end
        input_axis_tvalid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: byte 0x%0h never accepted", b);
        end
    endtask

    task automatic host_read(input string name, input logic [7:0] exp, input bit wait_rxf);
        if (wait_rxf) begin
            for (int n = 0; n < 10 && ft245_rxf_n; n++) tick(1);
            check({name, " rxf_n_before"}, ft245_rxf_n, 1'b0);
        end
        ft245_rd_n = 1'b0;
        tick(2);
        check({name, " oe_not_yet"}, ft245_d_oe, 1'b0);
        tick(1);
        check({name, " oe_clk3"}, ft245_d_oe, 1'b1);
        check({name, " d_out"}, ft245_d_out, exp);
        check({name, " rxf_n_active"}, ft245_rxf_n, 1'b1);
        tick(5);
        ft245_rd_n = 1'b1;
        tick(3);
        check({name, " oe_release"}, ft245_d_oe, 1'b0);
        tick(1);
        check({name, " rxf_n_hold"}, ft245_rxf_n, 1'b1);
        tick(2);
    endtask

    task automatic host_write(input string name, input logic [7:0] b, input bit chk);
        ft245_d_in = b;
        tick(3);
        ft245_wr_n = 1'b0;
        tick(3);
        if (chk) check({name, " txe_n_active"}, ft245_txe_n, 1'b1);
        tick(4);
        ft245_wr_n = 1'b1;
        tick(4);
        if (chk) check({name, " txe_n_hold"}, ft245_txe_n, 1'b1);
        tick(2);
        if (chk) check({name, " txe_n_free"}, ft245_txe_n, 1'b0);
    endtask

    task automatic pop_out(input string name, input logic [7:0] exp);
        check({name, " tvalid"}, output_axis_tvalid, 1'b1);
        check({name, " tdata"}, output_axis_tdata, exp);
        output_axis_tready = 1'b1;
        tick(1);
        output_axis_tready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;

        vecs[0] = '{is_wr: 1'b0, feed_en: 1'b1, data: 8'hA5, exp: 8'hA5, exp_err: 0};
        vecs[1] = '{is_wr: 1'b1, feed_en: 1'b0, data: 8'h3C, exp: 8'h3C, exp_err: 0};
        vecs[2] = '{is_wr: 1'b0, feed_en: 1'b0, data: 8'h00, exp: 8'h00, exp_err: 1};
        vecs[3] = '{is_wr: 1'b1, feed_en: 1'b0, data: 8'hFF, exp: 8'hFF, exp_err: 0};
        vecs[4] = '{is_wr: 1'b0, feed_en: 1'b1, data: 8'h5A, exp: 8'h5A, exp_err: 0};
        vecs[5] = '{is_wr: 1'b1, feed_en: 1'b0, data: 8'h00, exp: 8'h00, exp_err: 0};
        vecs[6] = '{is_wr: 1'b0, feed_en: 1'b1, data: 8'h81, exp: 8'h81, exp_err: 0};

        rst_n              = 1'b0;
        ft245_rd_n         = 1'b1;
        ft245_wr_n         = 1'b1;
        ft245_d_in         = 8'h00;
        input_axis_tdata   = 8'h00;
        input_axis_tvalid  = 1'b0;
        output_axis_tready = 1'b0;

        tick(2);
        check("rst d_oe", ft245_d_oe, 1'b0);
        check("rst d_out", ft245_d_out, 8'h00);
        check("rst rxf_n", ft245_rxf_n, 1'b1);
        check("rst txe_n", ft245_txe_n, 1'b1);
        check("rst in_tready", input_axis_tready, 1'b0);
        check("rst out_tvalid", output_axis_tvalid, 1'b0);
        check("rst protocol_err", protocol_err, 1'b0);

        rst_n = 1'b1;
        tick(2);
        check("idle in_tready", input_axis_tready, 1'b1);
        check("idle txe_n", ft245_txe_n, 1'b0);
        check("idle rxf_n", ft245_rxf_n, 1'b1);

        for (int i = 0; i < 7; i++) begin
            e0 = err_pulses;
            if (vecs[i].is_wr) begin
                host_write($sformatf("vec%0d", i), vecs[i].data, 1'b1);
                pop_out($sformatf("vec%0d", i), vecs[i].exp);
                check($sformatf("vec%0d tvalid_after_pop", i), output_axis_tvalid, 1'b0);
            end else begin
                if (vecs[i].feed_en) feed(vecs[i].data);
                host_read($sformatf("vec%0d", i), vecs[i].exp, vecs[i].feed_en);
                check($sformatf("vec%0d rxf_n_empty", i), ft245_rxf_n, 1'b1);
            end
            check($sformatf("vec%0d err_pulses", i), err_pulses - e0, vecs[i].exp_err);
        end

        // TX overflow: 17 writes with consumer stalled
        e0 = err_pulses;
        for (int i = 0; i < 17; i++) host_write("ovf", 8'(i), 1'b0);
        check("ovf err_pulses", err_pulses - e0, 1);
        check("ovf txe_n_full", ft245_txe_n, 1'b1);
        for (int i = 0; i < 16; i++) pop_out($sformatf("drain%0d", i), 8'(i));
        check("drain tvalid_empty", output_axis_tvalid, 1'b0);
        tick(1);
        check("drain txe_n_free", ft245_txe_n, 1'b0);

        // Both strobes low together: one pulse, both paths still work
        feed(8'h42);
        ft245_d_in = 8'h99;
        tick(3);
        e0 = err_pulses;
        ft245_rd_n = 1'b0;
        ft245_wr_n = 1'b0;
        tick(3);
        check("both d_oe", ft245_d_oe, 1'b1);
        check("both d_out", ft245_d_out, 8'h42);
        tick(5);
        ft245_rd_n = 1'b1;
        ft245_wr_n = 1'b1;
        tick(8);
        check("both err_pulses", err_pulses - e0, 1);
        check("both rxf_n_empty", ft245_rxf_n, 1'b1);
        pop_out("both", 8'h99);
        check("both tvalid_after_pop", output_axis_tvalid, 1'b0);

        // Write strobe falling during hold-off is rejected
        e0 = err_pulses;
        ft245_d_in = 8'h11;
        tick(3);
        ft245_wr_n = 1'b0;
        tick(7);
        ft245_wr_n = 1'b1;
        tick(2);
        ft245_d_in = 8'h22;
        ft245_wr_n = 1'b0;
        tick(6);
        ft245_wr_n = 1'b1;
        tick(8);
        check("hold err_pulses", err_pulses - e0, 1);
        pop_out("hold", 8'h11);
        check("hold tvalid_after_pop", output_axis_tvalid, 1'b0);

        // Loopback 0x01..0x40 in batches of 8, wrapping the RX pointers
        e0 = err_pulses;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) feed(8'(b * 8 + k + 1));
            for (int k = 0; k < 8; k++) host_read($sformatf("loop%0d", b * 8 + k + 1), 8'(b * 8 + k + 1), 1'b1);
        end
        check("loop err_pulses", err_pulses - e0, 0);
        check("loop rxf_n_empty", ft245_rxf_n, 1'b1);

        // Reset in the middle of a read
        feed(8'h77);
        ft245_rd_n = 1'b0;
        tick(4);
        check("midrst d_oe_before", ft245_d_oe, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst d_oe", ft245_d_oe, 1'b0);
        check("midrst rxf_n", ft245_rxf_n, 1'b1);
        check("midrst txe_n", ft245_txe_n, 1'b1);
        check("midrst out_tvalid", output_axis_tvalid, 1'b0);
        check("midrst in_tready", input_axis_tready, 1'b0);
        ft245_rd_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("postrst d_oe", ft245_d_oe, 1'b0);
        check("postrst rxf_n", ft245_rxf_n, 1'b1);
        check("postrst txe_n", ft245_txe_n, 1'b0);
        check("postrst in_tready", input_axis_tready, 1'b1);
        e0 = err_pulses;
        host_read("postrst", 8'h00, 1'b0);
        check("postrst err_pulses", err_pulses - e0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
